// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS core: owns the PC, runs the imem
// req/ready + rvalid handshake, and holds one instruction until the datapath retires it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic [5:0]       func,
  output logic [31:0]      pc,
  output logic             instr_valid,
  input  logic             retire,
  input  logic             pcsrc,
  input  logic             jump,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0]       pc4;
  logic [31:0]       br_off;
  logic [31:0]       jump_target;
  logic [31:0]       next_pc;

  // Next-PC selection uses the registered instruction, so only pcsrc/jump
  // are same-cycle inputs; jump wins over a taken branch.
  always_comb begin
    pc4         = pc_q + 32'd4;
    br_off      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    jump_target = {pc4[31:28], instr_q[25:0], 2'b00};
    next_pc     = pc4;
    if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = pc4 + br_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FETCH: begin
        if (req_q && imem_ready) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end else begin
          req_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // The request is a flop so it stays low through reset and rises on the
  // first clock edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign opcode        = instr_q[31:26];
  assign func          = instr_q[5:0];
  assign instr_valid   = valid_q;
  assign retired_count = cnt_q;

endmodule
